i2s_rx_stereo: RTL and testbench

Parametrised I2S/left-justified audio receiver running in the mclk domain. It oversamples externally supplied bclk/lrclk/sd and de-serialises both channels MSB-first, truncating each slot to DATA_W bits. Samples are tagged with their channel and buffered in a small FIFO behind a valid/ready stream interface feeding the downstream DSP chain. It reports overrun and short-slot framing errors.

---
 rtl/i2s_rx_stereo.sv | 172 +++++++++++++++++
 tb/tb_i2s_rx_stereo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_stereo.sv
// I2S / left-justified stereo receiver: oversamples bclk/lrclk/sd in the mclk
// domain, assembles MSB-first samples and queues {chan, sample} in a small FIFO.
module i2s_rx_stereo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LJ_MODE    = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sd,
  output logic [DATA_W-1:0] m_data,
  output logic              m_chan,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W1 = PTR_W + 1;
  localparam int unsigned ENT_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    DELAY     = 2'd1,
    SHIFT     = 2'd2,
    HOLD      = 2'd3
  } state_t;

  // Two-flop synchronisers plus a delayed bclk copy for edge detection.
  logic bclk_s1, bclk_s2, bclk_d;
  logic lrclk_s1, lrclk_s2;
  logic sd_s1, sd_s2;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1  <= 1'b0;
      bclk_s2  <= 1'b0;
      bclk_d   <= 1'b0;
      lrclk_s1 <= 1'b0;
      lrclk_s2 <= 1'b0;
      sd_s1    <= 1'b0;
      sd_s2    <= 1'b0;
    end else begin
      bclk_s1  <= bclk;
      bclk_s2  <= bclk_s1;
      bclk_d   <= bclk_s2;
      lrclk_s1 <= lrclk;
      lrclk_s2 <= lrclk_s1;
      sd_s1    <= sd;
      sd_s2    <= sd_s1;
    end
  end

  logic strobe_c;
  logic boundary_c;
  logic lr_prev;

  assign strobe_c   = bclk_s2 & ~bclk_d;
  assign boundary_c = strobe_c & (lrclk_s2 != lr_prev);

  // Word select seen at the previous strobe; tracked even while disabled.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev <= 1'b0;
    end else if (strobe_c) begin
      lr_prev <= lrclk_s2;
    end
  end

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-2:0]   shreg;
  logic                chan;
  logic [DATA_W-1:0]   sample_c;
  logic                push_c;

  assign sample_c = {shreg, sd_s2};
  assign push_c   = en & strobe_c & ~boundary_c & (state == SHIFT) &
                    (bit_cnt == CNT_W'(DATA_W - 1));

  // Slot FSM. In I2S mode the boundary bit still belongs to the previous
  // word, so DELAY skips it and the following strobe carries the MSB.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_EDGE;
      bit_cnt   <= '0;
      shreg     <= '0;
      chan      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!en) begin
        state   <= WAIT_EDGE;
        bit_cnt <= '0;
      end else if (strobe_c) begin
        if (boundary_c) begin
          chan <= lrclk_s2;
          if ((state == DELAY) || (state == SHIFT)) begin
            frame_err <= 1'b1;
          end
          if (LJ_MODE != 0) begin
            state   <= SHIFT;
            shreg   <= (DATA_W - 1)'(sd_s2);
            bit_cnt <= CNT_W'(1);
          end else begin
            state   <= DELAY;
            bit_cnt <= '0;
          end
        end else begin
          case (state)
            DELAY: begin
              state   <= SHIFT;
              shreg   <= (DATA_W - 1)'(sd_s2);
              bit_cnt <= CNT_W'(1);
            end
            SHIFT: begin
              shreg <= sample_c[DATA_W-2:0];
              if (bit_cnt < CNT_W'(DATA_W)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                state <= HOLD;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Output FIFO with an extra wrap bit on each pointer.
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              empty_c, full_c, pop_c, wr_en_c;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_c   = ~empty_c & m_ready;
  assign wr_en_c = push_c & (~full_c | pop_c);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      overrun <= push_c & full_c & ~pop_c;
      if (wr_en_c) begin
        mem[wr_ptr[PTR_W-1:0]] <= {chan, sample_c};
        wr_ptr                 <= wr_ptr + PTR_W1'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W1'(1);
      end
    end
  end

  assign m_valid          = ~empty_c;
  assign {m_chan, m_data} = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench: one serial stream feeds an I2S/16, an LJ/16 and an I2S/24
// receiver; popped samples are collected per instance and compared by hand values.
module tb_i2s_rx_stereo;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic rst_n, en, bclk, lrclk, sd;
  logic rdy_a, rdy_b, rdy_c;

  logic [15:0] da, db;
  logic [23:0] dc;
  logic ca, cb, cc, va, vb, vc;
  logic ovr_a, ovr_b, ovr_c, fe_a_s, fe_b_s, fe_c_s;

  i2s_rx_stereo #(.DATA_W(16), .LJ_MODE(0), .FIFO_DEPTH(4)) u_a (
    .mclk(mclk), .rst_n(rst_n), .en(en), .bclk(bclk), .lrclk(lrclk), .sd(sd),
    .m_data(da), .m_chan(ca), .m_valid(va), .m_ready(rdy_a),
    .overrun(ovr_a), .frame_err(fe_a_s));

  i2s_rx_stereo #(.DATA_W(16), .LJ_MODE(1), .FIFO_DEPTH(4)) u_b (
    .mclk(mclk), .rst_n(rst_n), .en(en), .bclk(bclk), .lrclk(lrclk), .sd(sd),
    .m_data(db), .m_chan(cb), .m_valid(vb), .m_ready(rdy_b),
    .overrun(ovr_b), .frame_err(fe_b_s));

  i2s_rx_stereo #(.DATA_W(24), .LJ_MODE(0), .FIFO_DEPTH(4)) u_c (
    .mclk(mclk), .rst_n(rst_n), .en(en), .bclk(bclk), .lrclk(lrclk), .sd(sd),
    .m_data(dc), .m_chan(cc), .m_valid(vc), .m_ready(rdy_c),
    .overrun(ovr_c), .frame_err(fe_c_s));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop monitor and pulse counters, sampled on the falling edge.
  logic [32:0] q_a[$], q_b[$], q_c[$];
  int ovf_a = 0, fe_a = 0, fe_b = 0, fe_c = 0;

  always @(negedge mclk) begin
    if (va && rdy_a) q_a.push_back({ca, 32'(da)});
    if (vb && rdy_b) q_b.push_back({cb, 32'(db)});
    if (vc && rdy_c) q_c.push_back({cc, 32'(dc)});
    ovf_a += int'(ovr_a);
    fe_a  += int'(fe_a_s);
    fe_b  += int'(fe_b_s);
    fe_c  += int'(fe_c_s);
  end

  int base_a, base_b, base_c, ovf0, fe0_a, fe0_b, fe0_c;
  logic [32:0] exp_q[$];

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic snap();
    base_a = q_a.size();
    base_b = q_b.size();
    base_c = q_c.size();
    ovf0   = ovf_a;
    fe0_a  = fe_a;
    fe0_b  = fe_b;
    fe0_c  = fe_c;
  endtask

  // One bclk period = 8 mclk; lrclk/sd change with the falling bclk edge.
  task automatic send_bit(input logic lr, input logic b);
    lrclk = lr;
    sd    = b;
    bclk  = 1'b0;
    repeat (4) tick();
    bclk = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_slot(input bit lj, input logic ch, input logic [31:0] w,
                           input int first, input int last);
    logic b;
    for (int k = first; k <= last; k++) begin
      if (lj) b = w[31-k];
      else    b = (k == 0) ? 1'b0 : w[32-k];
      send_bit(ch, b);
    end
  endtask

  task automatic send_frame(input bit lj, input logic [31:0] l, input logic [31:0] r);
    send_slot(lj, 1'b0, l, 0, 31);
    send_slot(lj, 1'b1, r, 0, 31);
  endtask

  // Park lrclk high with the receiver disabled so the next left slot is a fresh boundary.
  task automatic start_phase();
    en = 1'b0;
    repeat (4) send_bit(1'b1, 1'b0);
    en = 1'b1;
    snap();
  endtask

  function automatic logic [32:0] ent(input logic ch, input logic [31:0] d);
    return {ch, d};
  endfunction

  task automatic chk_stream(input string tag, input int which);
    logic [32:0] got[$];
    int base;
    case (which)
      0:       begin got = q_a; base = base_a; end
      1:       begin got = q_b; base = base_b; end
      default: begin got = q_c; base = base_c; end
    endcase
    chk({tag, "_count"}, 64'(got.size() - base), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (base + i < got.size()) begin
        chk($sformatf("%s[%0d]", tag, i), 64'(got[base + i]), 64'(exp_q[i]));
      end
    end
  endtask

  localparam logic [31:0] L16 = 32'hA5C3_0000;
  localparam logic [31:0] R16 = 32'h1234_0000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; bclk = 1'b0; lrclk = 1'b0; sd = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    repeat (5) tick();
    chk("rst_in_valid", 64'(va), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 64'(va), 64'(0));
    chk("rst_data", 64'(da), 64'(0));
    chk("rst_chan", 64'(ca), 64'(0));
    chk("rst_overrun", 64'(ovr_a), 64'(0));
    chk("rst_frame_err", 64'(fe_a_s), 64'(0));

    // Standard I2S frames.
    start_phase();
    repeat (2) send_frame(1'b0, L16, R16);
    repeat (16) tick();
    exp_q = {ent(0, 32'hA5C3), ent(1, 32'h1234), ent(0, 32'hA5C3), ent(1, 32'h1234)};
    chk_stream("i2s", 0);
    chk("i2s_overrun", 64'(ovf_a - ovf0), 64'(0));
    chk("i2s_frame_err", 64'(fe_a - fe0_a), 64'(0));

    // Left-justified frames: LJ receiver matches, I2S receiver is one bit late.
    start_phase();
    repeat (2) send_frame(1'b1, L16, R16);
    repeat (16) tick();
    chk_stream("lj", 1);
    chk("lj_frame_err", 64'(fe_b - fe0_b), 64'(0));
    exp_q = {ent(0, 32'h4B86), ent(1, 32'h2468), ent(0, 32'h4B86), ent(1, 32'h2468)};
    chk_stream("lj_into_i2s", 0);

    // 24-bit samples with non-zero trailing slot bits.
    start_phase();
    repeat (2) send_frame(1'b0, 32'h8000_01FF, 32'h7FFF_FFFF);
    repeat (16) tick();
    exp_q = {ent(0, 32'h80_0001), ent(1, 32'h7F_FFFF), ent(0, 32'h80_0001), ent(1, 32'h7F_FFFF)};
    chk_stream("w24", 2);
    chk("w24_frame_err", 64'(fe_c - fe0_c), 64'(0));
    exp_q = {ent(0, 32'h8000), ent(1, 32'h7FFF), ent(0, 32'h8000), ent(1, 32'h7FFF)};
    chk_stream("w24_into_16", 0);

    // Overrun: six samples into a four-entry FIFO with no consumer.
    rdy_a = 1'b0;
    start_phase();
    send_frame(1'b0, 32'h0101_0000, 32'h0202_0000);
    send_frame(1'b0, 32'h0303_0000, 32'h0404_0000);
    send_frame(1'b0, 32'h0505_0000, 32'h0606_0000);
    repeat (16) tick();
    chk("ovf_pulses", 64'(ovf_a - ovf0), 64'(2));
    chk("ovf_valid", 64'(va), 64'(1));
    chk("ovf_head_data", 64'(da), 64'(16'h0101));
    chk("ovf_head_chan", 64'(ca), 64'(0));
    rdy_a = 1'b1;
    repeat (10) tick();
    exp_q = {ent(0, 32'h0101), ent(1, 32'h0202), ent(0, 32'h0303), ent(1, 32'h0404)};
    chk_stream("ovf_drain", 0);
    chk("ovf_empty", 64'(va), 64'(0));

    // Short slot: only 10 data bits before lrclk toggles.
    start_phase();
    send_slot(1'b0, 1'b0, L16, 0, 10);
    send_slot(1'b0, 1'b1, R16, 0, 31);
    send_frame(1'b0, L16, R16);
    repeat (16) tick();
    chk("short_frame_err", 64'(fe_a - fe0_a), 64'(1));
    exp_q = {ent(1, 32'h1234), ent(0, 32'hA5C3), ent(1, 32'h1234)};
    chk_stream("short", 0);

    // Reset in the middle of a left slot with samples still queued.
    rdy_a = 1'b0;
    start_phase();
    send_frame(1'b0, L16, R16);
    send_slot(1'b0, 1'b0, L16, 0, 7);
    chk("pre_rst_valid", 64'(va), 64'(1));
    rst_n = 1'b0;
    repeat (3) tick();
    chk("mid_rst_valid", 64'(va), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(va), 64'(0));
    chk("post_rst_data", 64'(da), 64'(0));
    chk("post_rst_chan", 64'(ca), 64'(0));
    snap();
    rdy_a = 1'b1;
    send_slot(1'b0, 1'b0, L16, 8, 31);
    send_slot(1'b0, 1'b1, R16, 0, 31);
    send_frame(1'b0, L16, R16);
    repeat (16) tick();
    exp_q = {ent(1, 32'h1234), ent(0, 32'hA5C3), ent(1, 32'h1234)};
    chk_stream("after_rst", 0);
    chk("after_rst_frame_err", 64'(fe_a - fe0_a), 64'(0));

    // Enable dropped in the middle of a right slot.
    start_phase();
    send_slot(1'b0, 1'b0, L16, 0, 31);
    send_slot(1'b0, 1'b1, R16, 0, 7);
    en = 1'b0;
    repeat (20) tick();
    en = 1'b1;
    send_slot(1'b0, 1'b1, R16, 8, 31);
    send_frame(1'b0, L16, R16);
    repeat (16) tick();
    exp_q = {ent(0, 32'hA5C3), ent(0, 32'hA5C3), ent(1, 32'h1234)};
    chk_stream("en_drop", 0);
    chk("en_drop_frame_err", 64'(fe_a - fe0_a), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
